fb_port_arbiter: RTL and testbench
==================================

// Module: fb_port_arbiter
// PURPOSE
//  Sole controller of the single-port 8bpp framebuffer RAM: prefetches one visible line per LINE_START
//  into a small show-ahead pixel FIFO for scan-out, and interleaves host pixel writes in free slots.
//  Sits between the sync counters / pixel output stage (PIXEL_DATA consumer) and the framebuffer RAM.
//  Display fetch has priority; a wait-counter guarantees host writes cannot starve.
// PARAMETERS
//  H_BITS        10  log2 pixels per line; line length H_PIX = 2**H_BITS (1024)
//  V_BITS        10  line index width; ADDR_W = V_BITS+H_BITS (20)
//  FIFO_DEPTH    16  pixel FIFO entries (power of two)
//  LOW_WM         4  minimum FIFO count before a forced host slot may pre-empt display
//  HOST_MAX_WAIT  8  cycles a pending HOST_REQ may be refused before it is forced through
// PORTS
//  FCLK        in   1       pixel clock (DCM CLKFX output); all logic on rising edge
//  RST_IN      in   1       asynchronous, active-high reset
//  LINE_START  in   1       1-cycle pulse: begin prefetch of line LINE_Y
//  LINE_Y      in   V_BITS  line to fetch, sampled when LINE_START=1
//  PIX_RD      in   1       pop FIFO head (scan-out consumed PIXEL_DATA)
//  PIXEL_DATA  out  8       FIFO head, show-ahead; 0 when empty
//  PIX_VALID   out  1       FIFO not empty
//  UNDERRUN    out  1       1-cycle pulse, cycle after PIX_RD on empty FIFO
//  FETCH_BUSY  out  1       line fetch active (addresses outstanding or returns pending)
//  HOST_REQ    in   1       host write request; held with ADDR/WDATA stable until HOST_ACK
//  HOST_ADDR   in   ADDR_W  host write address
//  HOST_WDATA  in   8       host write data (RRRGGGBB)
//  HOST_ACK    out  1       1-cycle pulse, same cycle MEM_WE=1 for that write
//  MEM_ADDR    out  ADDR_W  RAM address (registered)
//  MEM_RE      out  1       RAM read strobe (registered)
//  MEM_WE      out  1       RAM write strobe (registered); never with MEM_RE
//  MEM_WDATA   out  8       RAM write data (registered)
//  MEM_RDATA   in   8       RAM read data, valid exactly 1 cycle after MEM_RE cycle
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, state IDLE, wait counter 0, in-flight pipe cleared; holds mid-op.
//  FSM: IDLE -(LINE_START)-> FETCH; FETCH -(x==H_PIX-1 issued)-> DRAIN; DRAIN -(no reads in flight)-> IDLE.
//   LINE_START in any state: FIFO flushed, in-flight returns tagged discard, x=0, line latched, -> FETCH.
//  Fetch address = {line, x}; x increments per issued read, 0..H_PIX-1, no wrap past end of line.
//  Credit: display slot wanted iff state FETCH and count+inflight < FIFO_DEPTH (inflight 0..2).
//  Slot decision per cycle (one of): forced host > display read > host write > idle.
//   host eligible: HOST_REQ=1 and HOST_ACK=0 this cycle (prevents double write of held request).
//   forced host: eligible and wait>=HOST_MAX_WAIT and count>=LOW_WM.
//   wait counter: +1 each cycle eligible host refused (saturates), 0 on grant or HOST_REQ=0.
//  Latency: decision in cycle n -> MEM_* valid cycle n+1 -> MEM_RDATA pushed into FIFO cycle n+2;
//   HOST_ACK asserted cycle n+1. Non-selected cycles drive MEM_RE=MEM_WE=0, MEM_ADDR/WDATA hold.
//  FIFO: push of returned data (unless discard-tagged) and pop in same cycle -> count unchanged;
//   push never overflows by credit rule; PIX_RD on empty -> no pop, UNDERRUN pulse next cycle.
//  FETCH_BUSY = state != IDLE. Host writes to the line being fetched are not coherent (by design).
// TESTING
//  1 LINE_START,LINE_Y=5, PIX_RD=0 -> MEM_ADDR 5120..5135 with MEM_RE, then stall; PIX_VALID=1,
//    PIXEL_DATA=mem[5120], count=16, FETCH_BUSY=1, no further MEM_RE.
//  2 test 1 then PIX_RD every cycle -> 1024 pixels mem[5120..6143] in order, UNDERRUN never,
//    FETCH_BUSY falls 2 cycles after last MEM_RE (addr 6143).
//  3 IDLE, HOST_REQ addr=0x00ABC data=0xE3 held -> exactly one MEM_WE cycle addr 0x00ABC data 0xE3,
//    HOST_ACK same cycle; no second write while REQ still high in ACK cycle.
//  4 fetch with PIX_RD every cycle (display wants every slot), HOST_REQ held -> HOST_ACK within
//    HOST_MAX_WAIT+2 = 10 cycles of REQ; no UNDERRUN; pixel order preserved.
//  5 PIX_RD on empty FIFO -> UNDERRUN=1 for one cycle, PIXEL_DATA=0; LINE_START LINE_Y=7 mid-line ->
//    FIFO empty next cycle, next MEM_ADDR=7168, stale return not pushed.
//  6 RST_IN asserted async mid-fetch with host pending -> all outputs 0 immediately; after release
//    no MEM_RE until new LINE_START; pending HOST_REQ served normally.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// fb_port_arbiter
//
// Only master of the single-port 8bpp framebuffer RAM. On each line-start
// pulse it prefetches one visible line into a small show-ahead pixel FIFO
// for scan-out. It places host pixel writes in the RAM slots that display
// fetch does not use. Display fetch normally wins a slot. A wait counter
// forces a stalled host write through once the FIFO holds enough pixels, so
// the host can never be starved.
//
// Ports
//   i_fclk         pixel clock, all logic on the rising edge
//   i_rst_in       asynchronous active-high reset
//   i_line_start   1-cycle pulse: flush and begin prefetch of line i_line_y
//   i_line_y       line to fetch, sampled with i_line_start
//   i_pix_rd       scan-out consumed o_pixel_data (pop FIFO head)
//   o_pixel_data   FIFO head (show-ahead), 0 when empty
//   o_pix_valid    FIFO not empty
//   o_underrun     1-cycle pulse, cycle after i_pix_rd on an empty FIFO
//   o_fetch_busy   a line fetch is active (state != IDLE)
//   i_host_req     host write request, held with addr/data until o_host_ack
//   i_host_addr    host write address {line, x}
//   i_host_wdata   host write data (RRRGGGBB)
//   o_host_ack     1-cycle pulse, same cycle as o_mem_we for that write
//   o_mem_addr     RAM address (registered, holds when idle)
//   o_mem_re       RAM read strobe (registered)
//   o_mem_we       RAM write strobe (registered), never together with o_mem_re
//   o_mem_wdata    RAM write data (registered, holds when idle)
//   i_mem_rdata    RAM read data, valid the cycle after o_mem_re
//   o_dbg_state    current FSM state (0 IDLE, 1 FETCH, 2 DRAIN)
//
// Handshakes
//   Host: i_host_req is held with stable address/data until o_host_ack. A
//   request is eligible only in cycles where o_host_ack is low, so a request
//   that is still high in its ack cycle is not written twice.
//   Scan-out: o_pix_valid/o_pixel_data present the FIFO head. i_pix_rd pops
//   it when valid. i_pix_rd with o_pix_valid low pops nothing and raises
//   o_underrun in the next cycle.
//
// Timing of a slot decided in cycle n: o_mem_* and o_host_ack are driven in
// cycle n+1. Read data returns in n+2 and is written into the FIFO at the
// end of n+2.
// ---------------------------------------------------------------------------
module fb_port_arbiter #(
  parameter int H_BITS        = 10,
  parameter int V_BITS        = 10,
  parameter int FIFO_DEPTH    = 16,
  parameter int LOW_WM        = 4,
  parameter int HOST_MAX_WAIT = 8,
  localparam int ADDR_W       = V_BITS + H_BITS
) (
  input  logic              i_fclk,
  input  logic              i_rst_in,
  input  logic              i_line_start,
  input  logic [V_BITS-1:0] i_line_y,
  input  logic              i_pix_rd,
  output logic [7:0]        o_pixel_data,
  output logic              o_pix_valid,
  output logic              o_underrun,
  output logic              o_fetch_busy,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic              o_host_ack,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  output logic              o_mem_we,
  output logic [7:0]        o_mem_wdata,
  input  logic [7:0]        i_mem_rdata,
  output logic [1:0]        o_dbg_state
);

  // FIFO pointer width, and count width (the count must be able to hold FIFO_DEPTH itself)
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // wait counter width, saturating at HOST_MAX_WAIT
  localparam int WW = $clog2(HOST_MAX_WAIT + 1);

  localparam logic [CW:0]     DEPTH_L  = (CW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]   LOW_L    = CW'(LOW_WM);
  localparam logic [WW-1:0]   WAIT_MAX = WW'(HOST_MAX_WAIT);
  localparam logic [H_BITS-1:0] X_LAST = {H_BITS{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state;
  logic [V_BITS-1:0] r_line;
  logic [H_BITS-1:0] r_x;

  // pixel FIFO
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;

  // In-flight read pipe. p1 runs alongside o_mem_re. p2 marks the cycle in
  // which i_mem_rdata carries the data. A flush clears the "live" bits so
  // returns from the old line are dropped, but the RAM strobes are left alone.
  logic              r_p1_live;
  logic              r_p2_live;

  logic [WW-1:0]     r_wait;

  logic [1:0]        w_inflight;
  logic [CW:0]       w_sum;
  logic              w_empty;
  logic              w_disp_want;
  logic              w_host_elig;
  logic              w_host_force;
  logic              w_grant_host;
  logic              w_grant_disp;
  logic              w_push;
  logic              w_pop;

  // -------------------------------------------------------------------------
  // Slot decision
  // -------------------------------------------------------------------------
  always_comb begin
    w_inflight  = {1'b0, r_p1_live} + {1'b0, r_p2_live};
    // count plus reads already issued must leave room for one more
    w_sum       = {1'b0, r_count} + {{(CW-1){1'b0}}, w_inflight};
    w_empty     = (r_count == '0);

    // A read decided in a line-start cycle would belong to the old line, so
    // display gives up that slot.
    w_disp_want = (r_state == ST_FETCH) && !i_line_start && (w_sum < DEPTH_L);

    w_host_elig  = i_host_req && !o_host_ack;
    w_host_force = w_host_elig && (r_wait >= WAIT_MAX) && (r_count >= LOW_L);

    // priority: forced host > display read > host write > idle
    w_grant_host = w_host_force || (w_host_elig && !w_disp_want);
    w_grant_disp = w_disp_want && !w_host_force;

    // a line start flushes the FIFO, which overrides this cycle's push and pop
    w_push = r_p2_live && !i_line_start;
    w_pop  = i_pix_rd && !w_empty && !i_line_start;
  end

  // -------------------------------------------------------------------------
  // FSM, RAM port registers, FIFO control, wait counter
  // -------------------------------------------------------------------------
  always_ff @(posedge i_fclk or posedge i_rst_in) begin
    if (i_rst_in) begin
      r_state     <= ST_IDLE;
      r_line      <= '0;
      r_x         <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_p1_live   <= 1'b0;
      r_p2_live   <= 1'b0;
      r_wait      <= '0;
      o_mem_addr  <= '0;
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_wdata <= '0;
      o_host_ack  <= 1'b0;
      o_underrun  <= 1'b0;
    end else begin
      // RAM strobes. Address and data hold when the slot is not used.
      o_mem_re   <= w_grant_disp;
      o_mem_we   <= w_grant_host;
      o_host_ack <= w_grant_host;
      if (w_grant_disp) begin
        o_mem_addr <= {r_line, r_x};
      end else if (w_grant_host) begin
        o_mem_addr  <= i_host_addr;
        o_mem_wdata <= i_host_wdata;
      end

      // read pipe; reads that are already issued become discard on line start
      r_p1_live <= w_grant_disp;
      r_p2_live <= r_p1_live && !i_line_start;

      o_underrun <= i_pix_rd && w_empty;

      // host wait counter
      if (!i_host_req || w_grant_host) begin
        r_wait <= '0;
      end else if (w_host_elig && (r_wait != WAIT_MAX)) begin
        r_wait <= r_wait + WW'(1);
      end

      // FIFO occupancy
      if (i_line_start) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end

      // FSM
      if (i_line_start) begin
        r_state <= ST_FETCH;
        r_line  <= i_line_y;
        r_x     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
          end
          ST_FETCH: begin
            if (w_grant_disp) begin
              // x stops at the last pixel; the line never wraps
              if (r_x == X_LAST) begin
                r_state <= ST_DRAIN;
              end else begin
                r_x <= r_x + H_BITS'(1);
              end
            end
          end
          ST_DRAIN: begin
            // The data that returns this cycle is the last read. Once no read
            // is in the p1 stage, nothing more is coming back.
            if (!r_p1_live) r_state <= ST_IDLE;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // FIFO storage has no reset; the count decides what is valid
  always_ff @(posedge i_fclk) begin
    if (w_push) r_fifo[r_wr_ptr] <= i_mem_rdata;
  end

  assign o_pix_valid  = !w_empty;
  assign o_pixel_data = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
  assign o_fetch_busy = (r_state != ST_IDLE);
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_port_arbiter
//
// Bench for fb_port_arbiter. It contains a RAM model with a one-cycle read
// latency and three expected queues: read addresses, pixel values and host
// writes. Each queue is filled when the stimulus is driven and emptied when
// the DUT produces the matching output.
// ---------------------------------------------------------------------------
module tb_fb_port_arbiter;

  localparam int H_BITS = 10;
  localparam int V_BITS = 10;
  localparam int AW     = 20;
  localparam int H_PIX  = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT signals ----------------
  logic              line_start = 1'b0;
  logic [V_BITS-1:0] line_y     = '0;
  logic              pix_rd     = 1'b0;
  logic [7:0]        pixel_data;
  logic              pix_valid;
  logic              underrun;
  logic              fetch_busy;
  logic              host_req   = 1'b0;
  logic [AW-1:0]     host_addr  = '0;
  logic [7:0]        host_wdata = '0;
  logic              host_ack;
  logic [AW-1:0]     mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata  = '0;
  logic [1:0]        dbg_state;

  fb_port_arbiter dut (
    .i_fclk       (clk),
    .i_rst_in     (rst),
    .i_line_start (line_start),
    .i_line_y     (line_y),
    .i_pix_rd     (pix_rd),
    .o_pixel_data (pixel_data),
    .o_pix_valid  (pix_valid),
    .o_underrun   (underrun),
    .o_fetch_busy (fetch_busy),
    .i_host_req   (host_req),
    .i_host_addr  (host_addr),
    .i_host_wdata (host_wdata),
    .o_host_ack   (host_ack),
    .o_mem_addr   (mem_addr),
    .o_mem_re     (mem_re),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- checker ----------------
  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- RAM model ----------------
  function automatic logic [7:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
  endfunction

  logic [7:0] wmem [int];

  function automatic logic [7:0] ram_rd(input logic [AW-1:0] a);
    if (wmem.exists(int'(a))) return wmem[int'(a)];
    return pat(a);
  endfunction

  always @(posedge clk) begin
    if (mem_we) wmem[int'(mem_addr)] = mem_wdata;
    mem_rdata <= mem_re ? ram_rd(mem_addr) : 8'h00;
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0]   addr_q [$];
  logic [7:0]      exp_q  [$];
  logic [AW+7:0]   host_q [$];

  int rd_cnt      = 0;
  int wr_cnt      = 0;
  int und_cnt     = 0;
  int pop_cnt     = 0;
  int last_re_cyc = 0;
  int fall_cyc    = 0;
  bit prev_busy   = 1'b0;
  bit exp_und     = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      exp_und   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (mem_re) begin
        rd_cnt++;
        last_re_cyc = cyc;
        check_eq("re_we_excl", 32'(mem_we), 0);
        check_eq("rd_q_avail", 32'(addr_q.size() > 0), 1);
        if (addr_q.size() > 0) check_eq("rd_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (mem_we) begin
        logic [AW+7:0] e;
        wr_cnt++;
        check_eq("we_with_ack", 32'(host_ack), 1);
        check_eq("wr_q_avail", 32'(host_q.size() > 0), 1);
        if (host_q.size() > 0) begin
          e = host_q.pop_front();
          check_eq("wr_addr", 32'(mem_addr), 32'(e[AW+7:8]));
          check_eq("wr_data", 32'(mem_wdata), 32'(e[7:0]));
        end
      end
      if (host_ack && !mem_we) check_eq("ack_needs_we", 32'(mem_we), 1);
      if (pix_rd && pix_valid && !line_start) begin
        pop_cnt++;
        check_eq("pix_q_avail", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check_eq("pixel", 32'(pixel_data), 32'(exp_q.pop_front()));
      end
      if (!pix_valid) check_eq("empty_pix_zero", 32'(pixel_data), 0);
      if (underrun || exp_und) check_eq("underrun", 32'(underrun), 32'(exp_und));
      if (underrun) und_cnt++;
      exp_und = pix_rd && !pix_valid;
      if (prev_busy && !fetch_busy) fall_cyc = cyc;
      prev_busy = fetch_busy;
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_line(input int y);
    logic [AW-1:0] a;
    line_start = 1'b1;
    line_y     = V_BITS'(y);
    tick(1);
    line_start = 1'b0;
    addr_q.delete();
    exp_q.delete();
    pop_cnt = 0;
    for (int x = 0; x < H_PIX; x++) begin
      a = {V_BITS'(y), H_BITS'(x)};
      addr_q.push_back(a);
      exp_q.push_back(pat(a));
    end
  endtask

  task automatic drain_line(input int max_cyc);
    int n = 0;
    pix_rd = 1'b1;
    while (pop_cnt < H_PIX && n < max_cyc) begin
      tick(1);
      n++;
    end
    pix_rd = 1'b0;
    check_eq("drain_done", 32'(pop_cnt), 32'(H_PIX));
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d, input int limit);
    int c0  = cyc;
    int lat = 0;
    bit seen = 1'b0;
    host_q.push_back({a, d});
    host_req   = 1'b1;
    host_addr  = a;
    host_wdata = d;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (host_ack) begin
        seen = 1'b1;
        lat  = cyc - c0;
        break;
      end
    end
    check_eq("host_ack_seen", 32'(seen), 1);
    check_eq("host_lat_ok", 32'(lat <= limit), 1);
    tick(1);
    host_req = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_pixel_data"}, 32'(pixel_data), 0);
    check_eq({tag, "_pix_valid"},  32'(pix_valid), 0);
    check_eq({tag, "_underrun"},   32'(underrun), 0);
    check_eq({tag, "_fetch_busy"}, 32'(fetch_busy), 0);
    check_eq({tag, "_host_ack"},   32'(host_ack), 0);
    check_eq({tag, "_mem_addr"},   32'(mem_addr), 0);
    check_eq({tag, "_mem_re"},     32'(mem_re), 0);
    check_eq({tag, "_mem_we"},     32'(mem_we), 0);
    check_eq({tag, "_mem_wdata"},  32'(mem_wdata), 0);
    check_eq({tag, "_state"},      32'(dbg_state), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int wr0;
    int rd0;
    int und0;
    bit seen;
    logic [AW-1:0] a6;

    // reset
    tick(3);
    @(negedge clk);
    check_outputs_zero("reset");
    tick(1);
    rst = 1'b0;
    tick(5);
    check_eq("idle_no_reads", 32'(rd_cnt), 0);

    // single host write while idle, request held through the ack cycle
    wr0 = wr_cnt;
    host_write(20'h00ABC, 8'hE3, 2);
    tick(5);
    check_eq("host_single_write", 32'(wr_cnt - wr0), 1);

    // prefetch line 5 with no scan-out: 16 reads, then stall
    rd0 = rd_cnt;
    start_line(5);
    tick(40);
    check_eq("fill_reads", 32'(rd_cnt - rd0), 16);
    check_eq("fill_valid", 32'(pix_valid), 1);
    check_eq("fill_head", 32'(pixel_data), 32'(pat(20'd5120)));
    check_eq("fill_busy", 32'(fetch_busy), 1);
    tick(10);
    check_eq("stall_reads", 32'(rd_cnt - rd0), 16);

    // scan out the whole line
    und0 = und_cnt;
    drain_line(3000);
    check_eq("line5_reads", 32'(rd_cnt - rd0), 32'(H_PIX));
    check_eq("line5_no_underrun", 32'(und_cnt - und0), 0);
    check_eq("line5_exp_left", 32'(exp_q.size()), 0);
    check_eq("line5_addr_left", 32'(addr_q.size()), 0);
    check_eq("busy_fall_delay", 32'(fall_cyc - last_re_cyc), 2);
    check_eq("line5_idle", 32'(fetch_busy), 0);

    // host write while display takes every slot
    und0 = und_cnt;
    start_line(9);
    tick(30);
    fork
      drain_line(3000);
      begin
        tick(20);
        host_write(20'h4B012, 8'h3C, 10);
      end
    join
    check_eq("line9_no_underrun", 32'(und_cnt - und0), 0);
    check_eq("line9_exp_left", 32'(exp_q.size()), 0);

    // underrun on an empty FIFO
    tick(5);
    pix_rd = 1'b1;
    tick(1);
    pix_rd = 1'b0;
    @(negedge clk);
    check_eq("underrun_pulse", 32'(underrun), 1);
    check_eq("underrun_pix0", 32'(pixel_data), 0);
    tick(1);
    @(negedge clk);
    check_eq("underrun_one_cycle", 32'(underrun), 0);

    // line start in the middle of a fetch, with reads still in flight
    tick(1);
    start_line(3);
    tick(6);
    start_line(7);
    @(negedge clk);
    check_eq("flush_empty", 32'(pix_valid), 0);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (mem_re) begin
        seen = 1'b1;
        check_eq("restart_addr", 32'(mem_addr), 32'd7168);
        break;
      end
      @(negedge clk);
    end
    check_eq("restart_read_seen", 32'(seen), 1);
    tick(30);
    check_eq("restart_head", 32'(pixel_data), 32'(pat(20'd7168)));

    // asynchronous reset in the middle of a fetch, with a host write pending
    pix_rd = 1'b1;
    tick(40);
    a6 = {10'd400, 10'd5};
    host_q.push_back({a6, 8'h5A});
    host_addr  = a6;
    host_wdata = 8'h5A;
    host_req   = 1'b1;
    #3 rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    pix_rd = 1'b0;
    exp_q.delete();
    addr_q.delete();
    tick(3);
    rst = 1'b0;
    rd0 = rd_cnt;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (host_ack) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("post_rst_host_ack", 32'(seen), 1);
    tick(1);
    host_req = 1'b0;
    tick(20);
    check_eq("post_rst_no_reads", 32'(rd_cnt - rd0), 0);
    check_eq("post_rst_idle", 32'(fetch_busy), 0);
    check_eq("host_q_left", 32'(host_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global bound on run time
  initial begin
    #2000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
